// File: rtl/gpi_cond_pkg.sv
// gpi_cond_pkg
//   Shared definitions for the GPIO input-conditioning stage.
//   - gpi_state_e    : per-channel debounce state (STABLE / PEND)
//   - GLITCHCNTBITSZ : width of the optional bounce-reject counter
//                      (built only when GPI_COND_GLITCHCNT_EN is defined)
package gpi_cond_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } gpi_state_e;

    localparam int GLITCHCNTBITSZ = 16;

endpackage

// File: rtl/gpi_cond_ch.sv
// gpi_cond_ch
//   One conditioned input: SYNCSTAGES-deep synchronizer, debounce counter,
//   two-state FSM and registered rise/fall pulses.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   STABLE | previous cycle ended with synchronized input equal to o,
//          | or a commit just happened; counter is 0
//   PEND   | synchronized input differs from o; counter counts PEND cycles
//
//   Ports
//     clk_i, rst_i (async, active-low)
//     thresh_i  : debounce threshold in clk_i cycles
//     i         : raw asynchronous pad input
//     o         : debounced level
//     rise_o    : 1-cycle pulse on o 0->1
//     fall_o    : 1-cycle pulse on o 1->0
//     abort_o   : (GPI_COND_GLITCHCNT_EN only) PEND->STABLE without commit
module gpi_cond_ch
    import gpi_cond_pkg::*;
#(
    parameter int   SYNCSTAGES = 2,
    parameter int   THRESBITSZ = 15,
    parameter logic INIT       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [THRESBITSZ-1:0] thresh_i,
    input  logic                  i,
    output logic                  o,
    output logic                  rise_o,
`ifdef GPI_COND_GLITCHCNT_EN
    output logic                  abort_o,
`endif
    output logic                  fall_o
);

    logic [SYNCSTAGES-1:0] r_sync;
    logic [THRESBITSZ-1:0] r_cnt;
    gpi_state_e            r_state;
    logic                  r_o;
    logic                  r_rise;
    logic                  r_fall;

    gpi_state_e            w_state_nxt;
    logic [THRESBITSZ-1:0] w_cnt_nxt;
    logic                  w_o_nxt;
    logic                  w_rise_nxt;
    logic                  w_fall_nxt;
    logic                  w_s;
    logic                  w_commit;

    assign w_s = r_sync[SYNCSTAGES-1];

    // Counter value is the number of PEND cycles already elapsed, so a
    // threshold of 0 commits on the very first mismatching cycle.
    assign w_commit = (r_cnt >= thresh_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync  <= {SYNCSTAGES{INIT}};
            r_cnt   <= '0;
            r_state <= STABLE;
            r_o     <= INIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNCSTAGES-2:0], i};
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_o     <= w_o_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
        w_o_nxt     = r_o;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE, PEND: begin
                // Both states react identically to a mismatch; they differ
                // only in whether a match means "abort" (see abort_o).
                if (w_s != r_o) begin
                    if (w_commit) begin
                        w_o_nxt    = w_s;
                        w_rise_nxt = w_s;
                        w_fall_nxt = ~w_s;
                    end else begin
                        w_state_nxt = PEND;
                        w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = STABLE;
            end
        endcase
    end

`ifdef GPI_COND_GLITCHCNT_EN
    assign abort_o = (r_state == PEND) && (w_s == r_o);
`endif

    assign o      = r_o;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/gpi_cond.sv
// gpi_cond
//   Input-conditioning stage in front of the GPIO input bus. Every bit is
//   synchronized into clk_i and debounced against a shared threshold; a
//   clean level plus registered rise/fall pulses are produced per bit.
//
//   Optional feature macro: GPI_COND_GLITCHCNT_EN
//     adds glitchcnt_o (saturating count of rejected bounces, all bits
//     summed per cycle) and glitchclr_i (synchronous clear, wins over
//     same-cycle increments).
//
//   Ports
//     clk_i, rst_i (async, active-low)
//     thresh_i [THRESBITSZ] : debounce threshold, sampled every cycle
//     i        [IOCOUNT]    : raw pad inputs
//     o        [IOCOUNT]    : debounced levels
//     rise_o   [IOCOUNT]    : 1-cycle 0->1 pulses
//     fall_o   [IOCOUNT]    : 1-cycle 1->0 pulses
module gpi_cond
    import gpi_cond_pkg::*;
#(
    parameter int   IOCOUNT    = 1,
    parameter int   THRESBITSZ = 15,
    parameter int   SYNCSTAGES = 2,
    parameter logic INIT       = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [THRESBITSZ-1:0]     thresh_i,
    input  logic [IOCOUNT-1:0]        i,
`ifdef GPI_COND_GLITCHCNT_EN
    input  logic                      glitchclr_i,
    output logic [GLITCHCNTBITSZ-1:0] glitchcnt_o,
`endif
    output logic [IOCOUNT-1:0]        o,
    output logic [IOCOUNT-1:0]        rise_o,
    output logic [IOCOUNT-1:0]        fall_o
);

`ifdef GPI_COND_GLITCHCNT_EN
    logic [IOCOUNT-1:0] w_abort;
`endif

    for (genvar k = 0; k < IOCOUNT; k++) begin : g_ch
        gpi_cond_ch #(
            .SYNCSTAGES (SYNCSTAGES),
            .THRESBITSZ (THRESBITSZ),
            .INIT       (INIT)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .thresh_i (thresh_i),
            .i        (i[k]),
            .o        (o[k]),
            .rise_o   (rise_o[k]),
`ifdef GPI_COND_GLITCHCNT_EN
            .abort_o  (w_abort[k]),
`endif
            .fall_o   (fall_o[k])
        );
    end

`ifdef GPI_COND_GLITCHCNT_EN
    // IOCOUNT is at most 63, so six bits hold the per-cycle abort total.
    localparam int ABORTSUMBITSZ = 6;

    logic [GLITCHCNTBITSZ-1:0] r_glitchcnt;
    logic [ABORTSUMBITSZ-1:0]  w_abort_sum;
    logic [GLITCHCNTBITSZ:0]   w_glitch_sum;

    always_comb begin
        w_abort_sum = '0;
        for (int k = 0; k < IOCOUNT; k++) begin
            w_abort_sum = w_abort_sum + {{(ABORTSUMBITSZ-1){1'b0}}, w_abort[k]};
        end
    end

    // One extra bit catches the carry so saturation needs no compare.
    assign w_glitch_sum = {1'b0, r_glitchcnt}
                        + {{(GLITCHCNTBITSZ+1-ABORTSUMBITSZ){1'b0}}, w_abort_sum};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_glitchcnt <= '0;
        end else if (glitchclr_i) begin
            r_glitchcnt <= '0;
        end else if (w_glitch_sum[GLITCHCNTBITSZ]) begin
            r_glitchcnt <= '1;
        end else begin
            r_glitchcnt <= w_glitch_sum[GLITCHCNTBITSZ-1:0];
        end
    end

    assign glitchcnt_o = r_glitchcnt;
`endif

endmodule
